// File: rtl/uart_arb_pkg.sv
// State encodings and sizing helpers shared by the UART transmit arbiter and its picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int DATA_W_DEF = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping, ptr_i itself last.
// Zero latency; no flow control of its own.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]        req_i,
    input  logic [idx_w(N_REQ)-1:0] ptr_i,
    output logic [idx_w(N_REQ)-1:0] win_o,
    output logic                    vld_o
);

    localparam int IW = idx_w(N_REQ);

    logic [IW-1:0] idx;

    always_comb begin
        win_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(ptr_i) + i) % N_REQ);
            if (!vld_o && req_i[idx]) begin
                vld_o = 1'b1;
                win_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART byte transmitter among N_REQ sources; UART_ARB_LOCK_EN adds a grant lock.
// Latency: req to tx_start 2 cycles; tx_done to next tx_start 2 cycles minimum.
// Backpressure: a source holds req until its ack; the arbiter stalls on tx_busy with no timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        req_lock,
`endif
    output logic [N_REQ-1:0]        ack,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [idx_w(N_REQ)-1:0] grant_id,
    output logic                    active,
    output logic                    tx_done
);

    localparam int            IW      = idx_w(N_REQ);
    localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              start_q, start_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    logic [N_REQ-1:0]  pick_req;
    logic [IW-1:0]     pick_win;
    logic              pick_vld;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;

    // ptr always equals the last grant, so masking to that one requester keeps the picker usable.
    always_comb begin
        pick_req = req;
        if (lock_q) begin
            pick_req           = '0;
            pick_req[grant_q]  = req[grant_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign pick_req = req;
`endif

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_i(pick_req),
        .ptr_i(ptr_q),
        .win_o(pick_win),
        .vld_o(pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ack_d    = '0;
        start_d  = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_ISSUE;
                    ptr_d   = pick_win;
                    grant_d = pick_win;
                    data_d  = req_data[int'(pick_win)*DATA_W +: DATA_W];
                end
            end
            ST_ISSUE: begin
                state_d         = ST_WAIT_BUSY;
                start_d         = 1'b1;
                ack_d[grant_q]  = 1'b1;
                active_d        = 1'b1;
            end
            ST_WAIT_BUSY: begin
                active_d = 1'b1;
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_busy) begin
                    active_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = req_lock[grant_q];
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign ack      = ack_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign grant_id = grant_q;
    assign active   = active_q;
    assign tx_done  = done_q;

endmodule
